// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle control sequencer for the rysyCore datapath.
//
// Owns every sequencing decision of the core: load wait cycles for a
// configurable memory latency, the single bubble after a store, the flush
// slots after a taken branch or jump, and the external freeze request.
// The purely combinational decode (ALU op, immediates, compare op) stays
// in ctrl.
//
// Parameters:
//   LOAD_LAT     cycles from load address issue to valid read data (1..8)
//   FLUSH_SLOTS  NOPs injected after a taken redirect (0..4)
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous, active-low reset
//   opcode     opcode of the instruction currently in execute
//   b          branch compare result, 1 = taken
//   ext_stall  freeze request from the memory/debug side
//   pc_sel     00 = ALU target, 01 = PC+4, 10 = hold
//   mem_sel    0 = PC fetch address, 1 = ALU data address
//   inst_sel   00 = fetched word, 01 = NOP, 10 = held instruction
//   reg_wr_en  gate ANDed with ctrl.reg_wr
//   busy       high whenever the sequencer is not in RUN
//   stall_cnt  saturating count of busy/stalled cycles
//
// Build option:
//   CTRL_SEQ_PERF_EN  when defined, stall_cnt is a live saturating counter;
//                     otherwise it is tied to zero and no flops are built.

module ctrl_seq #(
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic        b,
    input  logic        ext_stall,
    output logic [1:0]  pc_sel,
    output logic        mem_sel,
    output logic [1:0]  inst_sel,
    output logic        reg_wr_en,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_HOLD = 2'b10;

    localparam logic [1:0] INST_FETCH = 2'b00;
    localparam logic [1:0] INST_NOP   = 2'b01;
    localparam logic [1:0] INST_HOLD  = 2'b10;

    localparam logic [2:0] LOAD_CNT  = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_SLOTS);

    typedef enum logic [1:0] {
        RUN,
        LD_WAIT,
        LD_WB,
        FLUSH
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    // Decremented count, clamped so the shared counter can never wrap.
    logic [2:0] cnt_dec;
    assign cnt_dec = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;

    // State register and shared down counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and output decode. The stall override comes after the
    // per-state decode so it wins, but leaves mem_sel as the state chose it.
    // The reset override comes last so outputs react to rst without a clock.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_sel    = PC_INC;
        mem_sel   = 1'b0;
        inst_sel  = INST_FETCH;
        reg_wr_en = 1'b1;

        case (state)
            RUN: begin
                case (opcode)
                    OP_LOAD: begin
                        mem_sel   = 1'b1;
                        pc_sel    = PC_HOLD;
                        inst_sel  = INST_HOLD;
                        reg_wr_en = 1'b0;
                        cnt_nxt   = LOAD_CNT;
                        state_nxt = (LOAD_LAT == 1) ? LD_WB : LD_WAIT;
                    end
                    OP_STORE: begin
                        mem_sel   = 1'b1;
                        reg_wr_en = 1'b0;
                        cnt_nxt   = 3'd1;
                        state_nxt = FLUSH;
                    end
                    OP_JAL, OP_JALR: begin
                        pc_sel    = PC_ALU;
                        cnt_nxt   = FLUSH_CNT;
                        state_nxt = (FLUSH_SLOTS == 0) ? RUN : FLUSH;
                    end
                    OP_BRANCH: begin
                        if (b) begin
                            pc_sel    = PC_ALU;
                            cnt_nxt   = FLUSH_CNT;
                            state_nxt = (FLUSH_SLOTS == 0) ? RUN : FLUSH;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            LD_WAIT: begin
                mem_sel   = 1'b1;
                pc_sel    = PC_HOLD;
                inst_sel  = INST_HOLD;
                reg_wr_en = 1'b0;
                cnt_nxt   = cnt_dec;
                if (cnt <= 3'd1) begin
                    state_nxt = LD_WB;
                end
            end
            LD_WB: begin
                inst_sel  = INST_HOLD;
                state_nxt = RUN;
            end
            FLUSH: begin
                inst_sel  = INST_NOP;
                reg_wr_en = 1'b0;
                cnt_nxt   = cnt_dec;
                if (cnt <= 3'd1) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (ext_stall) begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pc_sel    = PC_HOLD;
            inst_sel  = INST_HOLD;
            reg_wr_en = 1'b0;
        end

        if (!rst) begin
            pc_sel    = PC_HOLD;
            mem_sel   = 1'b0;
            inst_sel  = INST_NOP;
            reg_wr_en = 1'b0;
        end
    end

    assign busy = (state != RUN);

`ifdef CTRL_SEQ_PERF_EN
    // Performance counter: counts every busy or frozen cycle, sticks at
    // all-ones instead of wrapping, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'h0000;
        end else if ((busy || ext_stall) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: self-checking bench for ctrl_seq.
//
// Four instances with different LOAD_LAT/FLUSH_SLOTS share one input bus;
// each test resets them all and checks one selected instance. Per-cycle
// vectors carry the inputs and the expected outputs; expectations are
// queued when the inputs are driven and popped when the outputs are
// sampled mid-cycle, away from the rising edge.

module tb_ctrl_seq;

    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] OP   = 7'b0110011;
    localparam logic [6:0] RES  = 7'b1111111;

`ifdef CTRL_SEQ_PERF_EN
    localparam logic [15:0] PERF_EXP = 16'd5;
`else
    localparam logic [15:0] PERF_EXP = 16'd0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       b;
    logic       ext_stall;

    logic [1:0]  pc_sel_d    [4];
    logic        mem_sel_d   [4];
    logic [1:0]  inst_sel_d  [4];
    logic        reg_wr_en_d [4];
    logic        busy_d      [4];
    logic [15:0] stall_cnt_d [4];

    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       stl;
        logic [1:0] pc;
        logic       mem;
        logic [1:0] inst;
        logic       wr;
        logic       bsy;
    } vec_t;

    typedef struct {
        logic [6:0] packed_exp;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   dut_idx = 0;

    always #5 clk = ~clk;

    ctrl_seq #(.LOAD_LAT(3), .FLUSH_SLOTS(2)) u_d0 (
        .clk(clk), .rst(rst), .opcode(opcode), .b(b), .ext_stall(ext_stall),
        .pc_sel(pc_sel_d[0]), .mem_sel(mem_sel_d[0]), .inst_sel(inst_sel_d[0]),
        .reg_wr_en(reg_wr_en_d[0]), .busy(busy_d[0]), .stall_cnt(stall_cnt_d[0]));

    ctrl_seq #(.LOAD_LAT(4), .FLUSH_SLOTS(0)) u_d1 (
        .clk(clk), .rst(rst), .opcode(opcode), .b(b), .ext_stall(ext_stall),
        .pc_sel(pc_sel_d[1]), .mem_sel(mem_sel_d[1]), .inst_sel(inst_sel_d[1]),
        .reg_wr_en(reg_wr_en_d[1]), .busy(busy_d[1]), .stall_cnt(stall_cnt_d[1]));

    ctrl_seq #(.LOAD_LAT(2), .FLUSH_SLOTS(4)) u_d2 (
        .clk(clk), .rst(rst), .opcode(opcode), .b(b), .ext_stall(ext_stall),
        .pc_sel(pc_sel_d[2]), .mem_sel(mem_sel_d[2]), .inst_sel(inst_sel_d[2]),
        .reg_wr_en(reg_wr_en_d[2]), .busy(busy_d[2]), .stall_cnt(stall_cnt_d[2]));

    ctrl_seq #(.LOAD_LAT(1), .FLUSH_SLOTS(1)) u_d3 (
        .clk(clk), .rst(rst), .opcode(opcode), .b(b), .ext_stall(ext_stall),
        .pc_sel(pc_sel_d[3]), .mem_sel(mem_sel_d[3]), .inst_sel(inst_sel_d[3]),
        .reg_wr_en(reg_wr_en_d[3]), .busy(busy_d[3]), .stall_cnt(stall_cnt_d[3]));

    // Builds one vector record: inputs first, then expected outputs.
    function automatic vec_t mk(input logic [6:0] op, input logic br, input logic stl,
                                input logic [1:0] pc, input logic mem,
                                input logic [1:0] inst, input logic wr, input logic bsy);
        vec_t v;
        v.op = op; v.br = br; v.stl = stl;
        v.pc = pc; v.mem = mem; v.inst = inst; v.wr = wr; v.bsy = bsy;
        return v;
    endfunction

    function automatic logic [6:0] actualOut(input int i);
        return {pc_sel_d[i], mem_sel_d[i], inst_sel_d[i], reg_wr_en_d[i], busy_d[i]};
    endfunction

    // Drives one cycle of inputs and queues what the selected DUT must show.
    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        opcode    = v.op;
        b         = v.br;
        ext_stall = v.stl;
        e.packed_exp = {v.pc, v.mem, v.inst, v.wr, v.bsy};
        e.name       = name;
        sb.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the selected DUT.
    task automatic checkOutput();
        exp_t       e;
        logic [6:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, want one queued");
        end else begin
            e   = sb.pop_front();
            act = actualOut(dut_idx);
            if (act !== e.packed_exp) begin
                errors++;
                $display("[TB] FAIL %s dut%0d: got {pc,mem,inst,wr,busy}=%b_%b_%b_%b_%b, want %b_%b_%b_%b_%b",
                         e.name, dut_idx, act[6:5], act[4], act[3:2], act[1], act[0],
                         e.packed_exp[6:5], e.packed_exp[4], e.packed_exp[3:2],
                         e.packed_exp[1], e.packed_exp[0]);
            end
        end
    endtask

    task automatic checkCount(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got stall_cnt=%0d, want %0d", name, act, exp);
        end
    endtask

    task automatic runVectors(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i], $sformatf("%s[%0d]", tag, i));
            #2;
            checkOutput();
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b0;
        opcode    = OP;
        b         = 1'b0;
        ext_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst       = 1'b0;
        opcode    = OP;
        b         = 1'b0;
        ext_stall = 1'b0;

        // Reset asserted mid-load (LOAD_LAT=4) must override outputs at once.
        doReset();
        dut_idx = 1;
        vecs = {};
        vecs.push_back(mk(LD, 0, 0, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(OP, 0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b10, 1, 2'b10, 0, 1));
        runVectors("rst_ldwait");
        rst = 1'b0;
        applyStimulus(mk(OP, 0, 0, 2'b10, 0, 2'b01, 0, 0), "rst_async_out");
        #1;
        checkOutput();
        checkCount("rst_stall_cnt", stall_cnt_d[1], 16'd0);
        @(negedge clk);
        rst = 1'b1;
        vecs = {};
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("rst_release");

        // LOAD_LAT=3 load, FLUSH_SLOTS=2 redirects, store, jump, reserved.
        doReset();
        dut_idx = 0;
        vecs = {};
        vecs.push_back(mk(LD,   0, 0, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b10, 1, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(BR,   1, 0, 2'b00, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(BR,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(ST,   0, 0, 2'b01, 1, 2'b00, 0, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(JAL,  0, 0, 2'b00, 0, 2'b00, 1, 0));
        vecs.push_back(mk(LD,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(ST,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(RES,  0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("main_d0");

        // Store bubble and zero-slot jump with FLUSH_SLOTS=0.
        doReset();
        dut_idx = 1;
        vecs = {};
        vecs.push_back(mk(ST,  0, 0, 2'b01, 1, 2'b00, 0, 0));
        vecs.push_back(mk(OP,  0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(OP,  0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(JAL, 0, 0, 2'b00, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP,  0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("slots0_d1");

        // Store bubble and four-slot JALR flush with FLUSH_SLOTS=4.
        doReset();
        dut_idx = 2;
        vecs = {};
        vecs.push_back(mk(ST,   0, 0, 2'b01, 1, 2'b00, 0, 0));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(JALR, 0, 0, 2'b00, 0, 2'b00, 1, 0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b01, 0, 1));
        end
        vecs.push_back(mk(OP,   0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("slots4_d2");

        // Two stalled cycles inside LD_WAIT stretch a 4-cycle load to 6.
        doReset();
        dut_idx = 0;
        vecs = {};
        vecs.push_back(mk(LD, 0, 0, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(OP, 0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 1, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 1, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b10, 1, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("stall_load_d0");

        // LOAD_LAT=1: stall on the issue cycle, direct write-back, stalled flush.
        doReset();
        dut_idx = 3;
        vecs = {};
        vecs.push_back(mk(LD, 0, 1, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(LD, 0, 0, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b10, 1, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        vecs.push_back(mk(BR, 1, 0, 2'b00, 0, 2'b00, 1, 0));
        vecs.push_back(mk(OP, 0, 1, 2'b10, 0, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b01, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("lat1_d3");

        // Perf counter: LOAD_LAT=2 load (2 busy cycles) plus 3 stalled cycles.
        doReset();
        dut_idx = 2;
        vecs = {};
        vecs.push_back(mk(LD, 0, 0, 2'b10, 1, 2'b10, 0, 0));
        vecs.push_back(mk(OP, 0, 0, 2'b10, 1, 2'b10, 0, 1));
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b10, 1, 1));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mk(OP, 0, 1, 2'b10, 0, 2'b10, 0, 0));
        end
        vecs.push_back(mk(OP, 0, 0, 2'b01, 0, 2'b00, 1, 0));
        runVectors("perf_d2");
        checkCount("perf_stall_cnt", stall_cnt_d[2], PERF_EXP);

        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
